// File: rtl/bti_rom_arb2_pkg.sv
// bti_rom_arb2_pkg: BTI packet types and arbiter constants shared by the bti_rom_arb2 slice.
package bti_rom_arb2_pkg;
  localparam int BTI_AW = 32;
  localparam int BTI_DW = 32;
  localparam int BTI_TIDW = 4;
  localparam int BTI_ROM_ARB_NREQ = 2;
  localparam int BTI_ROM_ARB_IDW = $clog2(BTI_ROM_ARB_NREQ);
  typedef struct packed {
    logic [BTI_AW-1:0] addr;
    logic [BTI_TIDW-1:0] tid;
  } bti_req_pkt_t;
  typedef struct packed {
    logic [BTI_TIDW-1:0] tid;
    logic [BTI_DW-1:0] data;
    logic ok;
  } bti_rsp_pkt_t;
endpackage

// File: rtl/bti_rom_arb2_if.sv
// bti_rom_arb2_if: BTI request and response handshake interfaces with master/slave modports.
interface bti_req_if_t;
  import bti_rom_arb2_pkg::*;
  logic vld;
  logic rdy;
  bti_req_pkt_t pkt;
  modport mst(output vld, output pkt, input rdy);
  modport slv(input vld, input pkt, output rdy);
endinterface

interface bti_rsp_if_t;
  import bti_rom_arb2_pkg::*;
  logic vld;
  logic rdy;
  bti_rsp_pkt_t pkt;
  modport mst(output vld, output pkt, input rdy);
  modport slv(input vld, input pkt, output rdy);
endinterface

// File: rtl/bti_rom_arb2_idq.sv
// bti_rom_arb2_idq: in-order FIFO of 1-bit requester IDs for outstanding downstream requests.
module bti_rom_arb2_idq #(
  parameter int DEPTH = 2,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head_id,
  output logic full,
  output logic empty
);
  logic [DEPTH-1:0] q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head_id = q[rd_ptr];
  // DEPTH is a power of two, so the pointers wrap for free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        q[wr_ptr] <= push_id;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/bti_rom_arb2.sv
// bti_rom_arb2: two-port BTI arbiter sharing one bti_rom, with in-order response steering.
// Define BTI_ROM_ARB_FIXED_PRIO_EN to give port 0 fixed priority instead of round-robin.
module bti_rom_arb2
  import bti_rom_arb2_pkg::*;
#(
  parameter int OST_DEPTH = 2,
  parameter int OST_AW = $clog2(OST_DEPTH)
) (
  input logic clk,
  input logic rst_n,
  bti_req_if_t.slv req0_slv,
  bti_rsp_if_t.mst rsp0_mst,
  bti_req_if_t.slv req1_slv,
  bti_rsp_if_t.mst rsp1_mst,
  bti_req_if_t.mst rom_req_mst,
  bti_rsp_if_t.slv rom_rsp_slv
);
  logic gnt, lock, lock_id, full, empty, head_id, push, pop;
`ifdef BTI_ROM_ARB_FIXED_PRIO_EN
  always_comb gnt = lock ? lock_id : (!req0_slv.vld & req1_slv.vld);
`else
  logic rr_ptr;
  always_comb gnt = lock ? lock_id : (req0_slv.vld & req1_slv.vld) ? rr_ptr : req1_slv.vld;
`endif
  assign rom_req_mst.vld = (gnt ? req1_slv.vld : req0_slv.vld) & !full;
  assign rom_req_mst.pkt = gnt ? req1_slv.pkt : req0_slv.pkt;
  assign req0_slv.rdy = !gnt & req0_slv.vld & rom_req_mst.rdy & !full;
  assign req1_slv.rdy = gnt & req1_slv.vld & rom_req_mst.rdy & !full;
  assign push = rom_req_mst.vld & rom_req_mst.rdy;
  assign rsp0_mst.vld = rom_rsp_slv.vld & !empty & !head_id;
  assign rsp1_mst.vld = rom_rsp_slv.vld & !empty & head_id;
  assign rsp0_mst.pkt = rom_rsp_slv.pkt;
  assign rsp1_mst.pkt = rom_rsp_slv.pkt;
  assign rom_rsp_slv.rdy = !empty & (head_id ? rsp1_mst.rdy : rsp0_mst.rdy);
  assign pop = rom_rsp_slv.vld & rom_rsp_slv.rdy;
  // a presented but stalled request pins the grant so vld/pkt stay stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock <= 1'b0;
      lock_id <= 1'b0;
`ifndef BTI_ROM_ARB_FIXED_PRIO_EN
      rr_ptr <= 1'b0;
`endif
    end else if (push) begin
      lock <= 1'b0;
`ifndef BTI_ROM_ARB_FIXED_PRIO_EN
      rr_ptr <= ~gnt;
`endif
    end else if (rom_req_mst.vld) begin
      lock <= 1'b1;
      lock_id <= gnt;
    end
  end
  bti_rom_arb2_idq #(.DEPTH(OST_DEPTH), .AW(OST_AW)) u_idq (
    .clk(clk), .rst_n(rst_n), .push(push), .push_id(gnt), .pop(pop),
    .head_id(head_id), .full(full), .empty(empty)
  );
  a_no_rsp_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(rom_rsp_slv.vld && empty));
endmodule

// File: tb/tb_bti_rom_arb2.sv
// tb_bti_rom_arb2: directed self-checking bench for bti_rom_arb2 with a 2-entry bti_rom model.
module tb_bti_rom_arb2;
  import bti_rom_arb2_pkg::*;
`ifdef BTI_ROM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  logic exp_rr = 1'b0;
  always #5 clk = ~clk;
  bti_req_if_t req0();
  bti_req_if_t req1();
  bti_req_if_t rom_req();
  bti_rsp_if_t rsp0();
  bti_rsp_if_t rsp1();
  bti_rsp_if_t rom_rsp();
  bti_rom_arb2 dut (
    .clk(clk), .rst_n(rst_n),
    .req0_slv(req0), .rsp0_mst(rsp0), .req1_slv(req1), .rsp1_mst(rsp1),
    .rom_req_mst(rom_req), .rom_rsp_slv(rom_rsp)
  );
  function automatic logic [31:0] rom_data(input logic [31:0] a);
    return (a[9:2] == 8'd4) ? 32'hDEADBEEF : {24'hC0DE00, a[9:2]};
  endfunction
  // bti_rom stand-in: one-cycle response latency, two response slots
  bti_rsp_pkt_t rf [2];
  logic rf_wp, rf_rp, rom_stall, rpush, rpop;
  logic [1:0] rf_cnt;
  assign rom_req.rdy = !rom_stall && rf_cnt != 2'd2;
  assign rom_rsp.vld = rf_cnt != 2'd0;
  assign rom_rsp.pkt = rf[rf_rp];
  assign rpush = rom_req.vld && rom_req.rdy;
  assign rpop = rom_rsp.vld && rom_rsp.rdy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wp <= 1'b0;
      rf_rp <= 1'b0;
      rf_cnt <= 2'd0;
    end else begin
      if (rpush) begin
        rf[rf_wp] <= '{tid: rom_req.pkt.tid, data: rom_data(rom_req.pkt.addr), ok: 1'b1};
        rf_wp <= !rf_wp;
      end
      if (rpop) rf_rp <= !rf_rp;
      rf_cnt <= rf_cnt + 2'(rpush) - 2'(rpop);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    rom_stall = 1'b0;
    req0.vld = 1'b0; req0.pkt = '0;
    req1.vld = 1'b0; req1.pkt = '0;
    rsp0.rdy = 1'b1; rsp1.rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++; if ({rom_req.vld, req0.rdy, req1.rdy, rsp0.vld, rsp1.vld, rom_rsp.rdy} !== 6'b0) $display("FAIL reset_outs[%0d] got %b exp 000000", i, {rom_req.vld, req0.rdy, req1.rdy, rsp0.vld, rsp1.vld, rom_rsp.rdy}); else n_pass++;
      n_chk++; if (dut.u_idq.empty !== 1'b1) $display("FAIL reset_empty[%0d] got %b exp 1", i, dut.u_idq.empty); else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    req0.vld = 1'b1; req0.pkt = '{addr: 32'h10, tid: 4'd3};
    @(negedge clk);
    n_chk++; if ({rom_req.vld, req0.rdy, req1.rdy} !== 3'b110 || rom_req.pkt !== req0.pkt) $display("FAIL single_req got vld/rdy0/rdy1=%b pkt=%h exp 110 pkt=%h", {rom_req.vld, req0.rdy, req1.rdy}, rom_req.pkt, req0.pkt); else n_pass++;
    @(posedge clk); #1;
    req0.vld = 1'b0;
    exp_rr = 1'b1;
    @(negedge clk);
    n_chk++; if ({rsp0.vld, rsp1.vld} !== 2'b10) $display("FAIL single_route got rsp0/rsp1 vld=%b exp 10", {rsp0.vld, rsp1.vld}); else n_pass++;
    n_chk++; if (rsp0.pkt !== '{tid: 4'd3, data: 32'hDEADBEEF, ok: 1'b1}) $display("FAIL single_rsp got %h exp tid 3 data deadbeef ok 1", rsp0.pkt); else n_pass++;
    @(negedge clk);
    n_chk++; if ({rsp0.vld, rsp1.vld, rom_rsp.rdy} !== 3'b000) $display("FAIL single_drain got %b exp 000", {rsp0.vld, rsp1.vld, rom_rsp.rdy}); else n_pass++;
  endtask

  task automatic test_both();
    int prev = -1;
    logic g;
    @(posedge clk); #1;
    req0.vld = 1'b1; req0.pkt = '{addr: 32'h0, tid: 4'd0};
    req1.vld = 1'b1; req1.pkt = '{addr: 32'h4, tid: 4'd1};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      g = FIXED ? 1'b0 : exp_rr;
      n_chk++; if ({rom_req.vld, req0.rdy, req1.rdy} !== {1'b1, !g, g} || rom_req.pkt.addr !== (g ? 32'h4 : 32'h0)) $display("FAIL rr_grant[%0d] got vld/rdy0/rdy1=%b addr=%h exp %b addr=%h", c, {rom_req.vld, req0.rdy, req1.rdy}, rom_req.pkt.addr, {1'b1, !g, g}, g ? 32'h4 : 32'h0); else n_pass++;
      if (prev >= 0) begin
        n_chk++; if ({rsp0.vld, rsp1.vld} !== {prev == 0, prev == 1} || rom_rsp.pkt.data !== rom_data(prev == 1 ? 32'h4 : 32'h0)) $display("FAIL rr_route[%0d] got vld=%b data=%h exp port %0d", c, {rsp0.vld, rsp1.vld}, rom_rsp.pkt.data, prev); else n_pass++;
      end
      prev = int'(g);
      exp_rr = !g;
    end
    @(posedge clk); #1;
    req0.vld = 1'b0; req1.vld = 1'b0;
    @(negedge clk);
    n_chk++; if ({rsp0.vld, rsp1.vld} !== {prev == 0, prev == 1} || rom_rsp.pkt.tid !== 4'(prev)) $display("FAIL rr_last got vld=%b tid=%h exp port %0d", {rsp0.vld, rsp1.vld}, rom_rsp.pkt.tid, prev); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_fill();
    @(posedge clk); #1;
    rsp0.rdy = 1'b0;
    req0.vld = 1'b1; req0.pkt = '{addr: 32'h8, tid: 4'd5};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_chk++; if ({rom_req.vld, req0.rdy} !== 2'b11) $display("FAIL fill_accept[%0d] got %b exp 11", c, {rom_req.vld, req0.rdy}); else n_pass++;
      @(posedge clk); #1;
    end
    req1.vld = 1'b1; req1.pkt = '{addr: 32'hC, tid: 4'd6};
    @(negedge clk);
    n_chk++; if ({rom_req.vld, req0.rdy, req1.rdy, rsp0.vld} !== 4'b0001) $display("FAIL fill_full got vld/rdy0/rdy1/rsp0=%b exp 0001", {rom_req.vld, req0.rdy, req1.rdy, rsp0.vld}); else n_pass++;
    @(posedge clk); #1;
    rsp0.rdy = 1'b1;
    @(negedge clk);
    n_chk++; if ({rom_req.vld, rsp0.vld, rsp1.vld, rom_rsp.rdy} !== 4'b0101 || rsp0.pkt.data !== rom_data(32'h8) || rsp0.pkt.tid !== 4'd5) $display("FAIL fill_pop got %b data=%h tid=%h exp 0101 data=%h tid=5", {rom_req.vld, rsp0.vld, rsp1.vld, rom_rsp.rdy}, rsp0.pkt.data, rsp0.pkt.tid, rom_data(32'h8)); else n_pass++;
    @(posedge clk); #1;
    req0.vld = 1'b0;
    @(negedge clk);
    n_chk++; if ({rom_req.vld, req1.rdy, rsp0.vld} !== 3'b111 || rom_req.pkt.addr !== 32'hC) $display("FAIL fill_resume got %b addr=%h exp 111 addr=c", {rom_req.vld, req1.rdy, rsp0.vld}, rom_req.pkt.addr); else n_pass++;
    @(posedge clk); #1;
    req1.vld = 1'b0;
    @(negedge clk);
    n_chk++; if ({rsp0.vld, rsp1.vld} !== 2'b01 || rsp1.pkt.data !== rom_data(32'hC) || rsp1.pkt.tid !== 4'd6) $display("FAIL fill_route got %b data=%h tid=%h exp 01 data=%h tid=6", {rsp0.vld, rsp1.vld}, rsp1.pkt.data, rsp1.pkt.tid, rom_data(32'hC)); else n_pass++;
    @(negedge clk);
    n_chk++; if ({rsp0.vld, rsp1.vld} !== 2'b00) $display("FAIL fill_idle got %b exp 00", {rsp0.vld, rsp1.vld}); else n_pass++;
  endtask

  task automatic test_hold();
    @(posedge clk); #1;
    rom_stall = 1'b1;
    req1.vld = 1'b1; req1.pkt = '{addr: 32'h14, tid: 4'd2};
    @(negedge clk);
    n_chk++; if ({rom_req.vld, req1.rdy} !== 2'b10 || rom_req.pkt.addr !== 32'h14) $display("FAIL hold_stall got %b addr=%h exp 10 addr=14", {rom_req.vld, req1.rdy}, rom_req.pkt.addr); else n_pass++;
    @(posedge clk); #1;
    req0.vld = 1'b1; req0.pkt = '{addr: 32'h18, tid: 4'd7};
    @(negedge clk);
    n_chk++; if ({rom_req.vld, req0.rdy, req1.rdy} !== 3'b100 || rom_req.pkt !== req1.pkt) $display("FAIL hold_locked got %b pkt=%h exp 100 pkt=%h", {rom_req.vld, req0.rdy, req1.rdy}, rom_req.pkt, req1.pkt); else n_pass++;
    @(posedge clk); #1;
    rom_stall = 1'b0;
    @(negedge clk);
    n_chk++; if ({rom_req.vld, req0.rdy, req1.rdy} !== 3'b101 || rom_req.pkt.addr !== 32'h14) $display("FAIL hold_release got %b addr=%h exp 101 addr=14", {rom_req.vld, req0.rdy, req1.rdy}, rom_req.pkt.addr); else n_pass++;
    @(posedge clk); #1;
    req1.vld = 1'b0;
    @(negedge clk);
    n_chk++; if ({rom_req.vld, req0.rdy, rsp1.vld} !== 3'b111 || rom_req.pkt.addr !== 32'h18 || rsp1.pkt.tid !== 4'd2) $display("FAIL hold_next got %b addr=%h tid=%h exp 111 addr=18 tid=2", {rom_req.vld, req0.rdy, rsp1.vld}, rom_req.pkt.addr, rsp1.pkt.tid); else n_pass++;
    @(posedge clk); #1;
    req0.vld = 1'b0;
    @(negedge clk);
    n_chk++; if ({rsp0.vld, rsp1.vld} !== 2'b10 || rsp0.pkt.data !== rom_data(32'h18)) $display("FAIL hold_route got %b data=%h exp 10 data=%h", {rsp0.vld, rsp1.vld}, rsp0.pkt.data, rom_data(32'h18)); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    rsp0.rdy = 1'b0;
    req0.vld = 1'b1; req0.pkt = '{addr: 32'h20, tid: 4'd1};
    repeat (2) @(posedge clk);
    #1;
    req0.vld = 1'b0;
    @(negedge clk);
    n_chk++; if ({rsp0.vld, dut.u_idq.full} !== 2'b11) $display("FAIL mid_outstanding got rsp0/full=%b exp 11", {rsp0.vld, dut.u_idq.full}); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if ({dut.u_idq.empty, rsp0.vld, rsp1.vld, rom_rsp.rdy, rom_req.vld} !== 5'b10000) $display("FAIL mid_cleared got %b exp 10000", {dut.u_idq.empty, rsp0.vld, rsp1.vld, rom_rsp.rdy, rom_req.vld}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rsp0.rdy = 1'b1;
    req1.vld = 1'b1; req1.pkt = '{addr: 32'h24, tid: 4'd4};
    @(negedge clk);
    n_chk++; if ({rom_req.vld, req0.rdy, req1.rdy} !== 3'b101 || rom_req.pkt.addr !== 32'h24) $display("FAIL mid_new_req got %b addr=%h exp 101 addr=24", {rom_req.vld, req0.rdy, req1.rdy}, rom_req.pkt.addr); else n_pass++;
    @(posedge clk); #1;
    req1.vld = 1'b0;
    @(negedge clk);
    n_chk++; if ({rsp0.vld, rsp1.vld} !== 2'b01 || rsp1.pkt !== '{tid: 4'd4, data: rom_data(32'h24), ok: 1'b1}) $display("FAIL mid_new_rsp got %b pkt=%h exp 01 tid=4 data=%h", {rsp0.vld, rsp1.vld}, rsp1.pkt, rom_data(32'h24)); else n_pass++;
    @(negedge clk);
    n_chk++; if ({rsp0.vld, rsp1.vld, dut.u_idq.empty} !== 3'b001) $display("FAIL mid_idle got %b exp 001", {rsp0.vld, rsp1.vld, dut.u_idq.empty}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_fill();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bti_rom_arb2.md
Name: bti_rom_arb2

Overview:
Two-requester BTI arbiter that shares one bti_rom slave between two masters, e.g. instruction fetch (port 0) and data load (port 1).
- Request path: round-robin grant with request hold, zero-latency pass-through to the single downstream BTI request master.
- Response path: an in-order outstanding-ID queue steers each downstream response back to the requester that issued it.
- Sits between the core-side BTI masters and bti_rom.

Parameters:
OST_DEPTH, 2, maximum outstanding downstream requests tracked (power of two, at least 2)
OST_AW, $clog2(OST_DEPTH), queue pointer width (derived, not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req0_slv  bti_req_if_t.slv  intf  requester 0 request (vld, rdy, pkt.addr, pkt.tid)
rsp0_mst  bti_rsp_if_t.mst  intf  requester 0 response (vld, rdy, pkt.tid, pkt.data, pkt.ok)
req1_slv  bti_req_if_t.slv  intf  requester 1 request
rsp1_mst  bti_rsp_if_t.mst  intf  requester 1 response
rom_req_mst  bti_req_if_t.mst  intf  request to bti_rom
rom_rsp_slv  bti_rsp_if_t.slv  intf  response from bti_rom

Behaviour:
- Single clock domain on clk. rst_n is asynchronous active-low; it clears every register.
- Reset state: rr_ptr=0 (port 0 has priority), lock=0, lock_id=0, queue empty (wr_ptr=rd_ptr=0, cnt=0).
- With both upstream vld low, all outputs are 0: rom_req_mst.vld, req*.rdy, rsp*.vld, rom_rsp_slv.rdy.
- Grant selection (combinational):
  - if lock=1, gnt=lock_id;
  - else if exactly one reqN.vld is high, gnt=N;
  - else if both are high, gnt=rr_ptr;
  - else no grant.
- Request pass-through:
  - rom_req_mst.vld = reqgnt.vld & !full
  - rom_req_mst.pkt = reqgnt.pkt, passed unmodified
  - reqgnt.rdy = rom_req_mst.rdy & !full
  - the non-granted req.rdy = 0
- Accept: a request handshake occurs when rom_req_mst.vld & rom_req_mst.rdy. On accept:
  - push gnt into the queue;
  - rr_ptr <= ~gnt;
  - lock <= 0.
- Hold rule: if rom_req_mst.vld=1 and rom_req_mst.rdy=0, then lock <= 1 and lock_id <= gnt. The grant cannot switch while a presented request is pending, which preserves BTI vld/pkt stability.
- Full queue: when cnt==OST_DEPTH, no request is presented (vld=0) and lock is not set. A push is not allowed in the same cycle as a pop while full; this keeps rsp.rdy out of the request path.
- Response routing: head = queue[rd_ptr].
  - rsphead.vld = rom_rsp_slv.vld & !empty
  - rsphead.pkt = rom_rsp_slv.pkt (tid, data, ok unmodified)
  - rom_rsp_slv.rdy = rsphead.rdy & !empty
  - the other rsp.vld = 0
- Pop on rom_rsp_slv.vld & rom_rsp_slv.rdy.
- Simultaneous push and pop when not full: cnt is unchanged and both pointers advance.
- Pointer wrap: pointers wrap modulo OST_DEPTH; cnt is OST_AW+1 bits wide.
- Latency: zero added cycles on both paths. bti_rom's one-cycle reg_slice gives back-to-back throughput of 1 request/cycle.
- Protocol error: rom_rsp_slv.vld while the queue is empty is dropped (rdy=0). A simulation-only assertion fires on this.
- Reset mid-transaction: the queue and lock are cleared, and any in-flight response is discarded. bti_rom must be reset by the same rst_n.

Optional Feature:
BTI_ROM_ARB_FIXED_PRIO_EN
- Defined: when both vld are high with lock=0, port 0 always wins. rr_ptr is not implemented.
- Undefined: round-robin as above.
- The hold/lock rule applies in both builds.

Decomposition:
- bti.svh: add `BTI_ROM_ARB_NREQ (2) and the requester ID width macro.
- Sub-module bti_rom_arb_idq: synchronous FIFO of 1-bit IDs, depth OST_DEPTH.
  - Ports: clk, rst_n, push, push_id, pop, head_id, full, empty.
  - Asynchronous reset to empty.
- The top level holds only grant/lock logic and muxing.

Test Plan:
- Reset with both vld=0 -> all vld/rdy outputs 0 and queue empty; after release, the same values hold until the first vld.
- Port 0 only, addr 0x10, tid 3, ROM[4]=0xDEADBEEF -> accepted in cycle 0; rsp0 arrives next cycle with data 0xDEADBEEF, tid 3, ok=1; rsp1.vld stays 0.
- Both ports issue continuously (addr 0x0 and 0x4) -> grants alternate 0,1,0,1; responses are steered to the matching ports in order; in the fixed-priority build, port 0 gets every grant.
- Requester 0 holds rsp0.rdy=0 for 3 cycles -> the queue fills to 2; rom_req_mst.vld=0 and both req.rdy=0 until rsp0.rdy rises; no response is lost or misrouted.
- Force rom_req_mst.rdy=0 while port 1 is granted, then raise req0.vld -> the grant stays on port 1 (lock=1) with pkt stable until accept, and port 0 is served next.
- Assert rst_n=0 with 2 requests outstanding -> the queue empties immediately; after release, a new port 1 request completes with correct data and routing.
